// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU types for the hazard controller: forwarding select encoding,
// the hardwired-zero register index, and the shadow pipeline entry.
package cpu_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd31;

  // Operand source select for the ID-stage read data muxes.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // What the controller did in the previous cycle. FLUSH means the
  // instruction now in ID is a squashed bubble.
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } hz_state_t;

  // Destination register and write/load flags of an in-flight instruction.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              ld;
  } shadow_t;

  localparam shadow_t SHADOW_EMPTY = '{rd: ZERO_REG, wr: 1'b0, ld: 1'b0};

  // Pick the operand source for one read port. The EX writer is the
  // youngest and wins over MEM; a load still in EX has no data yet, so it
  // never forwards from EX (that case is handled by the load-use stall).
  function automatic fwd_sel_t fwd_pick(input logic              rd_en,
                                        input logic [REG_AW-1:0] r,
                                        input shadow_t           ex,
                                        input shadow_t           mem,
                                        input logic [REG_AW-1:0] zero);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (rd_en && (r != zero)) begin
      if (ex.wr && (ex.rd == r) && !ex.ld) begin
        sel = FWD_EX;
      end else if (mem.wr && (mem.rd == r)) begin
        sel = FWD_MEM;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage bundle between the datapath (master) and the hazard controller
// (slave). All signals are level signals sampled every cycle; there is no
// valid/ready handshake: the controller answers combinationally in the same
// cycle, and the datapath acts on the answer at the next rising edge.
interface hazard_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);

  // ID-stage instruction information
  logic [ADDR_W-1:0] Rn;
  logic [ADDR_W-1:0] Ab;
  logic              use_a;
  logic              use_b;
  logic [ADDR_W-1:0] Rd_id;
  logic              RegWrite_id;
  logic              MemRead_id;
  logic              BrTaken_id;

  // Pipeline control back to the datapath
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              pc_we;
  logic              ifid_we;
  logic              ifid_flush;
  logic              idex_bubble;
  logic [CNT_W-1:0]  stall_count;
  cpu_pkg::hz_state_t fsm_state;

  modport master (
    output Rn, Ab, use_a, use_b, Rd_id, RegWrite_id, MemRead_id, BrTaken_id,
    input  fwd_a, fwd_b, pc_we, ifid_we, ifid_flush, idex_bubble,
           stall_count, fsm_state
  );

  modport slave (
    input  Rn, Ab, use_a, use_b, Rd_id, RegWrite_id, MemRead_id, BrTaken_id,
    output fwd_a, fwd_b, pc_we, ifid_we, ifid_flush, idex_bubble,
           stall_count, fsm_state
  );

endinterface

// File: rtl/hazard_ctrl_shadow_reg.sv
// One stage of the shadow pipeline: remembers rd/wr/ld of the instruction
// currently occupying a real pipeline stage.
module hazard_shadow_reg
  import cpu_pkg::*;
#(
  parameter shadow_t RST_VAL = SHADOW_EMPTY
) (
  input  logic    clk,
  input  logic    reset_n,
  input  shadow_t d,
  output shadow_t q
);

  // Advance every cycle; reset empties the stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage CPU: operand forwarding,
// load-use stall, taken-branch IF/ID flush and a saturating stall counter.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = REG_AW,
  parameter logic [ADDR_W-1:0] ZERO_REG = cpu_pkg::ZERO_REG,
  parameter int                CNT_W    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  hazard_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  shadow_t          ex_q;
  shadow_t          mem_q;
  shadow_t          ex_d;
  hz_state_t        state_q;
  hz_state_t        state_d;
  logic             id_v;
  logic             stall;
  logic             flush;
  fwd_sel_t         sel_a;
  fwd_sel_t         sel_b;
  logic [ADDR_W-1:0] rd_id;
  logic [CNT_W-1:0] stall_cnt_q;

  // The instruction in ID is real unless IF/ID was squashed last cycle.
  assign id_v  = (state_q != ST_FLUSH);
  assign rd_id = bus.Rd_id;

  // A stalled instruction must not be recorded in EX: it is replayed next
  // cycle, and EX receives the same bubble as the real ID/EX register.
  assign ex_d = '{rd: rd_id,
                  wr: bus.RegWrite_id & id_v & !stall,
                  ld: bus.MemRead_id  & id_v & !stall};

  hazard_shadow_reg u_ex (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (ex_d),
    .q       (ex_q)
  );

  hazard_shadow_reg u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (ex_q),
    .q       (mem_q)
  );

  // Controller state register; FLUSH doubles as the registered flush flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Hazard detection and next state; a stall outranks a taken branch so the
  // branch is re-evaluated once its operand can be forwarded.
  always_comb begin
    stall = 1'b0;
    if (id_v && ex_q.ld && ex_q.wr && (ex_q.rd != ZERO_REG)) begin
      stall = (bus.use_a && (bus.Rn == ex_q.rd)) ||
              (bus.use_b && (bus.Ab == ex_q.rd));
    end
    flush   = bus.BrTaken_id && id_v && !stall;
    state_d = ST_RUN;
    if (stall) begin
      state_d = ST_STALL;
    end else if (flush) begin
      state_d = ST_FLUSH;
    end
  end

  // Pipeline control outputs; forwarding selects are parked at regfile
  // during a stall since the ID/EX contents are discarded anyway.
  always_comb begin
    sel_a = FWD_RF;
    sel_b = FWD_RF;
    if (!stall) begin
      sel_a = fwd_pick(id_v & bus.use_a, bus.Rn, ex_q, mem_q, ZERO_REG);
      sel_b = fwd_pick(id_v & bus.use_b, bus.Ab, ex_q, mem_q, ZERO_REG);
    end
    bus.fwd_a       = sel_a;
    bus.fwd_b       = sel_b;
    bus.pc_we       = !stall;
    bus.ifid_we     = !stall;
    bus.ifid_flush  = flush;
    bus.idex_bubble = stall;
    bus.fsm_state   = state_q;
    bus.stall_count = stall_cnt_q;
  end

  // Count stall cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each driven cycle pushes its hand-computed
// expected outputs into a queue, and a negedge monitor pops and compares.
module tb_hazard_ctrl;

  logic clk;
  logic reset_n;

  hazard_ctrl_if #(.ADDR_W(5), .CNT_W(32)) hif ();

  hazard_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (hif.slave)
  );

  // Expected vector: {fwd_a, fwd_b, pc_we, ifid_we, ifid_flush, idex_bubble, stall_count}
  logic [39:0] exp_q[$];
  string       name_q[$];
  int          checks;
  int          errors;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  function automatic logic [39:0] pk(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic pc, input logic ifw,
                                     input logic fl, input logic bub,
                                     input logic [31:0] sc);
    return {fa, fb, pc, ifw, fl, bub, sc};
  endfunction

  function automatic logic [39:0] nrm(input logic [31:0] sc);
    return pk(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, sc);
  endfunction

  function automatic logic [39:0] stl(input logic [31:0] sc);
    return pk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, sc);
  endfunction

  // driver: apply one ID-stage cycle just after the rising edge
  task automatic drive(input logic rst, input logic [4:0] rn, input logic [4:0] ab,
                       input logic ua, input logic ub, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic br,
                       input logic [39:0] exp, input string nm);
    @(posedge clk);
    #1;
    reset_n         = rst;
    hif.Rn          = rn;
    hif.Ab          = ab;
    hif.use_a       = ua;
    hif.use_b       = ub;
    hif.Rd_id       = rd;
    hif.RegWrite_id = rw;
    hif.MemRead_id  = mr;
    hif.BrTaken_id  = br;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  // scoreboard monitor: compare mid-cycle, away from the rising edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [39:0] e;
      logic [39:0] a;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {hif.fwd_a, hif.fwd_b, hif.pc_we, hif.ifid_we, hif.ifid_flush,
           hif.idex_bubble, hif.stall_count};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got fa=%b fb=%b pc=%b ifid=%b fl=%b bub=%b sc=%0d, expected fa=%b fb=%b pc=%b ifid=%b fl=%b bub=%b sc=%0d",
                 n, a[39:38], a[37:36], a[35], a[34], a[33], a[32], a[31:0],
                 e[39:38], e[37:36], e[35], e[34], e[33], e[32], e[31:0]);
      end
    end
  end

  initial begin
    checks          = 0;
    errors          = 0;
    reset_n         = 1'b0;
    hif.Rn          = '0;
    hif.Ab          = '0;
    hif.use_a       = 1'b0;
    hif.use_b       = 1'b0;
    hif.Rd_id       = '0;
    hif.RegWrite_id = 1'b0;
    hif.MemRead_id  = 1'b0;
    hif.BrTaken_id  = 1'b0;
    repeat (2) @(posedge clk);

    //      rst  Rn  Ab  ua  ub  Rd  rw  mr  br  expected
    drive(1'b0, 0,  0,  0,  0,  0,  0,  0,  0, nrm(0), "rst_hold");
    drive(1'b1, 0,  0,  0,  0,  0,  0,  0,  0, nrm(0), "rel_nop");
    // ADD X1 then readers: EX forward on A, then MEM forward on B
    drive(1'b1, 2,  3,  1,  1,  1,  1,  0,  0, nrm(0), "add_x1");
    drive(1'b1, 1,  4,  1,  1,  6,  1,  0,  0, pk(2'b01, 2'b00, 1, 1, 0, 0, 0), "fwd_a_ex");
    drive(1'b1, 6,  1,  1,  1,  0,  0,  0,  0, pk(2'b01, 2'b10, 1, 1, 0, 0, 0), "fwd_b_mem");
    drive(1'b1, 7,  6,  0,  0,  0,  0,  0,  0, nrm(0), "use_gated");
    // two writers of X7: youngest (EX) wins
    drive(1'b1, 0,  0,  0,  0,  7,  1,  0,  0, nrm(0), "x7_old");
    drive(1'b1, 0,  0,  0,  0,  7,  1,  0,  0, nrm(0), "x7_new");
    drive(1'b1, 7,  7,  1,  1,  0,  0,  0,  0, pk(2'b01, 2'b01, 1, 1, 0, 0, 0), "ex_over_mem");
    drive(1'b1, 7,  0,  0,  0,  0,  0,  0,  0, nrm(0), "nop_a");
    // LDUR X2 ; ADD X4 <- X2 : one stall, then MEM forward
    drive(1'b1, 9,  0,  1,  0,  2,  1,  1,  0, nrm(0), "ldur_x2");
    drive(1'b1, 2,  3,  1,  1,  4,  1,  0,  0, stl(0), "lu_stall");
    drive(1'b1, 2,  3,  1,  1,  4,  1,  0,  0, pk(2'b10, 2'b00, 1, 1, 0, 0, 1), "lu_fwd_mem");
    drive(1'b1, 4,  0,  1,  0,  0,  0,  0,  0, pk(2'b01, 2'b00, 1, 1, 0, 0, 1), "after_stall_ex");
    // load-use on both operands: still a single stall
    drive(1'b1, 0,  0,  0,  0, 10,  1,  1,  0, nrm(1), "ldur_x10");
    drive(1'b1, 10, 10, 1,  1,  0,  0,  0,  0, stl(1), "lu_both_stall");
    drive(1'b1, 10, 10, 1,  1,  0,  0,  0,  0, pk(2'b10, 2'b10, 1, 1, 0, 0, 2), "lu_both_fwd");
    // X31 is never forwarded and never stalls
    drive(1'b1, 0,  0,  0,  0, 31,  1,  0,  0, nrm(2), "wr_x31");
    drive(1'b1, 31, 31, 1,  1, 31,  1,  1,  0, nrm(2), "rd_x31_ex");
    drive(1'b1, 31, 31, 1,  1,  0,  0,  0,  0, nrm(2), "rd_x31_ld");
    drive(1'b1, 0,  0,  0,  0,  0,  0,  0,  0, nrm(2), "nop_b");
    // taken branch: one-cycle flush, following slot is a bubble
    drive(1'b1, 0,  0,  0,  0,  0,  0,  0,  1, pk(2'b00, 2'b00, 1, 1, 1, 0, 2), "br_flush");
    drive(1'b1, 5,  0,  1,  0,  5,  1,  0,  1, nrm(2), "flush_bubble");
    drive(1'b1, 5,  5,  1,  1,  0,  0,  0,  0, nrm(2), "bubble_ignored");
    drive(1'b1, 0,  0,  0,  0,  0,  0,  0,  0, nrm(2), "nop_c");
    // LDUR X3 ; CBZ X3 taken: stall wins, then flush with MEM forward
    drive(1'b1, 0,  0,  0,  0,  3,  1,  1,  0, nrm(2), "ldur_x3");
    drive(1'b1, 0,  3,  0,  1,  0,  0,  0,  1, stl(2), "cbz_stall");
    drive(1'b1, 0,  3,  0,  1,  0,  0,  0,  1, pk(2'b00, 2'b10, 1, 1, 1, 0, 3), "cbz_flush");
    drive(1'b1, 0,  0,  0,  0,  0,  0,  0,  1, nrm(3), "cbz_bubble");
    // reset in the middle of a stall
    drive(1'b1, 0,  0,  0,  0,  1,  1,  1,  0, nrm(3), "ldur_x1");
    drive(1'b1, 1,  0,  1,  0,  0,  0,  0,  0, stl(3), "pre_rst_stall");
    drive(1'b0, 1,  0,  1,  0,  0,  0,  0,  0, nrm(0), "rst_mid_stall");
    drive(1'b1, 1,  0,  1,  0,  0,  0,  0,  0, nrm(0), "rst_first_instr");
    drive(1'b1, 0,  0,  0,  0,  0,  0,  0,  0, nrm(0), "rst_nop");

    // let the monitor drain, bounded
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage CPU. It sits beside the ID-stage datapath (register file read ports Rn/Ab, write port Rd_wb).
- Keeps a shadow copy of the destination register and write/load flags for the instructions in EX and MEM.
- From these it drives operand forwarding selects, load-use stalls, IF/ID flush on taken branches, and a stall performance counter.

Parameters:
- ADDR_W, 5, register address width.
- ZERO_REG, 31, hardwired-zero register index (X31/XZR); never forwarded and never the cause of a stall.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Rn  in  ADDR_W  ID read register 1.
- Ab  in  ADDR_W  ID read register 2 (output of the Reg2Loc mux).
- use_a  in  1  ID instruction reads Rn.
- use_b  in  1  ID instruction reads Ab.
- Rd_id  in  ADDR_W  ID destination register.
- RegWrite_id  in  1  ID instruction writes the register file.
- MemRead_id  in  1  ID instruction is a load (LDUR).
- BrTaken_id  in  1  branch resolved taken in ID.
- fwd_a  out  2  Da source: 00 = regfile, 01 = EX ALU result, 10 = MEM result.
- fwd_b  out  2  Db source, same encoding as fwd_a.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID register write enable.
- ifid_flush  out  1  squash the IF/ID contents at the next edge.
- idex_bubble  out  1  load a NOP into ID/EX at the next edge.
- stall_count  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - Shadow EX/MEM entries cleared (wr = 0, ld = 0, rd = ZERO_REG).
  - flush_q = 0 and stall_count = 0.
  - Resulting outputs: fwd_a = fwd_b = 00, pc_we = ifid_we = 1, ifid_flush = 0, idex_bubble = 0.
  - Reset asserted mid-stall aborts the stall; the first cycle after release behaves as an empty pipeline.
- ID valid (id_v):
  - id_v = !flush_q.
  - flush_q registers ifid_flush, so the cycle after a flush the ID inputs are a bubble.
  - When id_v = 0: no hazard is detected, fwd = 00, and a bubble enters the EX shadow.
- Shadow pipeline, advanced every cycle:
  - MEM <= EX.
  - EX <= {Rd_id, RegWrite_id & id_v & !stall, MemRead_id & id_v & !stall}.
  - A stall therefore inserts a bubble into EX in lockstep with idex_bubble.
- Forwarding, combinational from current state; operand A shown, B identical with Ab/use_b:
  - Condition: use_a & id_v & Rn != ZERO_REG.
  - EX match (ex.wr & ex.rd == Rn & !ex.ld) -> 01.
  - Else MEM match (mem.wr & mem.rd == Rn) -> 10.
  - Else 00.
  - EX has priority over MEM (youngest writer wins).
  - WB-to-ID is covered by the register file's write-before-read; this block does not handle it.
- Load-use stall:
  - stall = id_v & ex.ld & ex.wr & ex.rd != ZERO_REG & ((use_a & Rn == ex.rd) | (use_b & Ab == ex.rd)).
  - When stall: pc_we = 0, ifid_we = 0, idex_bubble = 1, and fwd_a/fwd_b are don't-care (drive 00).
  - Exactly one stall cycle per load-use pair. The next cycle the load is in MEM and the operand is forwarded with 10.
- Branch flush:
  - ifid_flush = BrTaken_id & id_v & !stall.
  - A stall has priority: the branch is re-evaluated after the stall using its forwarded operand.
  - The flush lasts one cycle; pc_we stays 1 so the target is fetched.
- Stall counter: stall_count increments on each rising edge where stall = 1 and saturates at all-ones (no wrap).
- Simultaneous events:
  - Load-use hazard on both operands -> a single stall cycle.
  - ifid_flush and idex_bubble are never asserted together.
- State machine (implicit in flush_q/stall): states RUN, STALL, FLUSH.
  - RUN -> STALL on stall.
  - RUN -> FLUSH on ifid_flush.
  - STALL -> RUN always, since the hazard clears in one cycle.
  - FLUSH -> RUN always.

Decomposition:
- Shared package cpu_pkg holds:
  - typedef fwd_sel_t (2-bit enum FWD_RF, FWD_EX, FWD_MEM).
  - ZERO_REG constant.
  - struct shadow_t {rd, wr, ld}.
- One sub-module, hazard_shadow_reg: a single shadow pipeline stage register with async active-low reset. It is instantiated twice (EX, MEM).

Test Plan:
- Reset: hold reset_n = 0 mid-operation with the shadow pipeline populated, then release -> all outputs at reset values, stall_count = 0, and no forwarding on the first instruction.
- ADD X1 in ID, next cycle SUB reads Rn = X1 (use_a = 1) -> fwd_a = 01. Following cycle, an instruction reading Ab = X1 -> fwd_b = 10.
- LDUR X2 followed by ADD reading X2 -> one cycle of pc_we = 0, ifid_we = 0, idex_bubble = 1, then fwd = 10; stall_count goes 0 -> 1.
- Writer targeting X31 followed by a reader of X31 -> fwd = 00 and no stall.
- BrTaken_id = 1 with no hazard -> ifid_flush = 1 for one cycle. Next cycle the ID inputs claim RegWrite_id = 1, Rd_id = X5, and a following reader of X5 sees fwd = 00 (bubble ignored).
- LDUR X3 then CBZ X3 with BrTaken_id = 1 -> the stall wins (ifid_flush = 0 that cycle). The next cycle asserts ifid_flush = 1 with fwd_b = 10.
